sum_pipe: RTL and testbench



---
 rtl/sum_pipe.sv | 124 ++++++++++++
 tb/tb_sum_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_pipe.sv
// sum_pipe: pipelined two-operand adder with valid/ready handshaking.
// Arithmetic is done in stage 0; the other stages only carry the result
// forward. Each stage is ready when it is empty or when everything below it
// can move, so a full pipe keeps streaming at one result per cycle as long
// as the consumer takes results.
//
// MODE 0 : unsigned wrap,     ovf = carry out
// MODE 1 : unsigned saturate, ovf = carry out, result clamps to all ones
// MODE 2 : signed saturate,   ovf = two's complement overflow, clamps to
//          the most positive / most negative value
module sum_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int MODE   = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Per-stage state: valid bit, result and overflow flag.
  logic [STAGES-1:0] stg_v;
  logic [WIDTH-1:0]  stg_c [STAGES];
  logic [STAGES-1:0] stg_o;
  logic [STAGES-1:0] stg_rdy;

  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  calc_c;
  logic              calc_ovf;
  logic              rdy_acc;
  logic              out_fire;

  // Stage-0 arithmetic on a WIDTH+1 bit sum; the carry never reaches c.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    calc_c   = sum[WIDTH-1:0];
    calc_ovf = 1'b0;
    case (MODE)
      1: begin
        calc_ovf = sum[WIDTH];
        if (calc_ovf) calc_c = ALL_ONES;
      end
      2: begin
        // Overflow only when both operands share a sign the result lacks.
        calc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        if (calc_ovf) calc_c = a[WIDTH-1] ? SMIN : SMAX;
      end
      default: begin
        calc_ovf = sum[WIDTH];
      end
    endcase
  end

  // Ready chain: a stage can load when any stage at or below it is empty or
  // the consumer is taking the output. Built bottom-up with an accumulator so
  // no bit of stg_rdy depends on another bit of itself.
  always_comb begin
    stg_rdy = '0;
    rdy_acc = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy_acc    = rdy_acc | ~stg_v[i];
      stg_rdy[i] = rdy_acc;
    end
  end

  assign in_ready  = stg_rdy[0] & ~areset;
  assign out_valid = stg_v[STAGES-1];
  assign c         = stg_c[STAGES-1];
  assign ovf       = stg_o[STAGES-1];
  assign out_fire  = out_valid & out_ready;

  // Pipeline advance: each ready stage takes the contents of the one above;
  // stalled stages hold. Payload only loads with a valid entry.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      stg_v <= '0;
      stg_o <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stg_c[i] <= '0;
      end
    end else begin
      if (stg_rdy[0]) begin
        stg_v[0] <= in_valid;
        if (in_valid) begin
          stg_c[0] <= calc_c;
          stg_o[0] <= calc_ovf;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (stg_rdy[i]) begin
          stg_v[i] <= stg_v[i-1];
          if (stg_v[i-1]) begin
            stg_c[i] <= stg_c[i-1];
            stg_o[i] <= stg_o[i-1];
          end
        end
      end
    end
  end

  // Count delivered overflowed results; sticks at all ones.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ovf_cnt <= '0;
    end else if (out_fire && ovf && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sum_pipe.sv
// Directed bench for sum_pipe: three instances (one per MODE) share the same
// input stream, WIDTH=8, STAGES=2. Inputs change 1 time unit after the
// rising edge; outputs are checked at that point too.
module tb_sum_pipe;

  logic       clk;
  logic       areset;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;

  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [7:0]  c0, c1, c2;
  logic        ovf0, ovf1, ovf2;
  logic [15:0] cnt0, cnt1, cnt2;

  int checks = 0;
  int errors = 0;

  sum_pipe #(.WIDTH(8), .STAGES(2), .MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .c(c0), .ovf(ovf0), .ovf_cnt(cnt0)
  );

  sum_pipe #(.WIDTH(8), .STAGES(2), .MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .c(c1), .ovf(ovf1), .ovf_cnt(cnt1)
  );

  sum_pipe #(.WIDTH(8), .STAGES(2), .MODE(2), .CNT_W(16)) u2 (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
    .c(c2), .ovf(ovf2), .ovf_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset    = 1'b1;
    in_valid  = 1'b0;
    a         = 8'd0;
    b         = 8'd0;
    out_ready = 1'b1;
    step();
    step();
    areset = 1'b0;
    step();
  endtask

  int s1a [6] = '{2, 20, 4, 40, 2, 20};
  int s1b [6] = '{3, 30, 5, 50, 1, 10};
  int s1c [6] = '{5, 50, 9, 90, 3, 30};

  int s3a [4] = '{8'h64, 8'h9C, 8'hFF, 8'h7F};
  int s3b [4] = '{8'h32, 8'hCE, 8'h01, 8'h80};
  int s3c2[4] = '{8'h7F, 8'h80, 8'h00, 8'hFF};
  int s3o2[4] = '{1, 1, 0, 0};
  int s3c0[4] = '{8'h96, 8'h6A, 8'h00, 8'hFF};
  int s3o0[4] = '{0, 1, 1, 0};

  initial begin
    areset    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 8'd0;
    b         = 8'd0;

    // Reset state, sampled before any clock edge.
    #3;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_c", c0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_in_ready0", in_ready0, 0);
    chk("rst_in_ready2", in_ready2, 0);
    step();
    areset = 1'b0;
    step();

    // 1: back-to-back wrap adds, no stalls.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      a = 8'(s1a[i]);
      b = 8'(s1b[i]);
      #1;
      chk("s1_in_ready", in_ready0, 1);
      step();
      if (i == 0) begin
        chk("s1_latency_ov", out_valid0, 0);
      end else begin
        chk("s1_ov", out_valid0, 1);
        chk("s1_c", c0, s1c[i-1]);
        chk("s1_ovf", ovf0, 0);
      end
    end
    in_valid = 1'b0;
    step();
    chk("s1_c_last", c0, s1c[5]);
    chk("s1_ov_last", out_valid0, 1);
    step();
    chk("s1_drained", out_valid0, 0);
    chk("s1_cnt", cnt0, 0);

    // 2: carry handling in wrap / unsigned saturate.
    do_reset();
    in_valid = 1'b1; a = 8'd200; b = 8'd100;
    step();
    a = 8'd255; b = 8'd0;
    step();
    in_valid = 1'b0;
    chk("s2_m0_c", c0, 44);
    chk("s2_m0_ovf", ovf0, 1);
    chk("s2_m1_c", c1, 255);
    chk("s2_m1_ovf", ovf1, 1);
    chk("s2_m2_c", c2, 44);
    chk("s2_m2_ovf", ovf2, 0);
    chk("s2_cnt_pre", cnt0, 0);
    step();
    chk("s2_m0_cnt", cnt0, 1);
    chk("s2_m1_cnt", cnt1, 1);
    chk("s2_m2_cnt", cnt2, 0);
    chk("s2_m1_c_ff", c1, 255);
    chk("s2_m1_ovf_ff", ovf1, 0);
    chk("s2_m0_c_ff", c0, 255);
    step();
    chk("s2_drained", out_valid1, 0);
    chk("s2_m1_cnt_hold", cnt1, 1);

    // 3: signed saturation corner pairs.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_valid = 1'b1;
        a = 8'(s3a[i]);
        b = 8'(s3b[i]);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 4) begin
        chk("s3_m2_c", c2, s3c2[i-1]);
        chk("s3_m2_ovf", ovf2, s3o2[i-1]);
        chk("s3_m0_c", c0, s3c0[i-1]);
        chk("s3_m0_ovf", ovf0, s3o0[i-1]);
      end
    end
    chk("s3_m2_cnt", cnt2, 2);
    chk("s3_m1_cnt", cnt1, 2);
    chk("s3_m0_cnt", cnt0, 2);
    chk("s3_drained", out_valid2, 0);

    // 4: backpressure fills two slots, third pair waits at the producer.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd1; b = 8'd1;
    #1;
    chk("s4_rdy1", in_ready0, 1);
    step();
    a = 8'd2; b = 8'd2;
    #1;
    chk("s4_rdy2", in_ready0, 1);
    step();
    a = 8'd3; b = 8'd3;
    #1;
    chk("s4_full_rdy", in_ready0, 0);
    chk("s4_full_ov", out_valid0, 1);
    chk("s4_full_c", c0, 2);
    step();
    chk("s4_stall_c", c0, 2);
    chk("s4_stall_rdy", in_ready0, 0);
    step();
    chk("s4_stall_c2", c0, 2);
    chk("s4_stall_ov", out_valid0, 1);
    out_ready = 1'b1;
    #1;
    chk("s4_release_rdy", in_ready0, 1);
    step();
    in_valid = 1'b0;
    chk("s4_out2", c0, 4);
    step();
    chk("s4_out3", c0, 6);
    chk("s4_out3_ov", out_valid0, 1);
    step();
    chk("s4_drained", out_valid0, 0);

    // 5: full pipe with simultaneous input and output every cycle.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; a = 8'(k * 3); b = 8'(k + 1);
      step();
    end
    out_ready = 1'b1;
    for (int k = 2; k < 12; k++) begin
      in_valid = 1'b1; a = 8'(k * 3); b = 8'(k + 1);
      #1;
      chk("s5_in_ready", in_ready0, 1);
      chk("s5_ov", out_valid0, 1);
      chk("s5_c", c0, (k - 2) * 4 + 1);
      step();
    end
    in_valid = 1'b0;
    chk("s5_c10", c0, 41);
    step();
    chk("s5_c11", c0, 45);
    chk("s5_ov11", out_valid0, 1);
    step();
    chk("s5_drained", out_valid0, 0);

    // 6: asynchronous reset with results in flight.
    do_reset();
    in_valid = 1'b1; a = 8'd200; b = 8'd100;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("s6_cnt_pre", cnt0, 1);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd1; b = 8'd2;
    step();
    a = 8'd3; b = 8'd4;
    step();
    in_valid = 1'b0;
    #2;
    chk("s6_full_ov", out_valid0, 1);
    areset = 1'b1;
    #1;
    chk("s6_async_ov", out_valid0, 0);
    chk("s6_async_c", c0, 0);
    chk("s6_async_cnt", cnt0, 0);
    chk("s6_async_rdy", in_ready0, 0);
    #1;
    areset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("s6_no_stale1", out_valid0, 0);
    step();
    chk("s6_no_stale2", out_valid0, 0);
    in_valid = 1'b1; a = 8'd7; b = 8'd8;
    step();
    in_valid = 1'b0;
    step();
    chk("s6_result_ov", out_valid0, 1);
    chk("s6_result_c", c0, 15);
    step();
    chk("s6_only_one", out_valid0, 0);
    step();
    chk("s6_only_one2", out_valid0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
